// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: frame sequencer for the conv engine's SIPO window shift register.
// Latency: sipo_en/sipo_ser_in are combinational from the accept; win_valid/win_row/win_col
//   are registered one cycle after the accept that completes a window.
// Backpressure: in_ready drops for the one FLUSH cycle at each row start and outside STREAM;
//   there is no downstream backpressure, so the conv core takes every win_valid cycle.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start, abort    begin a frame (IDLE only) / return to IDLE next cycle (abort wins)
//   in_valid, in_data, in_ready   raster word stream, accepted when in_valid & in_ready
//   sipo_en, sipo_ser_in          SIPO shift enable (low clears it) and the word to shift in
//   win_valid, win_row, win_col   SIPO output holds a full window at (row, leftmost col)
//   busy, frame_done, underrun    status: not idle, end-of-frame pulse, sticky mid-row stall
module conv_window_ctrl #(
   parameter int N     = 3,
   parameter int PB    = 8,
   parameter int IMG_W = 8,
   parameter int IMG_H = 4,
   localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1,
   localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic            in_valid,
   input  logic [2*PB-1:0] in_data,
   output logic            in_ready,
   output logic            sipo_en,
   output logic [2*PB-1:0] sipo_ser_in,
   output logic            win_valid,
   output logic [RW-1:0]   win_row,
   output logic [CW-1:0]   win_col,
   output logic            busy,
   output logic            frame_done,
   output logic            underrun
);

   localparam int             RNW      = $clog2(N + 1);
   localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0]  COL_BACK = CW'(N - 1);
   localparam logic [RNW-1:0] RUN_FULL = RNW'(N);
   localparam logic [RNW-1:0] RUN_PRE  = RNW'(N - 1);

   typedef enum logic [1:0] {IDLE, FLUSH, STREAM, DONE} state_t;

   state_t         state;
   logic [RW-1:0]  row;
   logic [CW-1:0]  col;
   // Consecutive words shifted into the SIPO since it was last cleared, saturating at N.
   logic [RNW-1:0] run;
   logic           acc;

   assign acc         = in_ready & in_valid;
   // The SIPO clears whenever its enable is low, so gating it on acc both holds off
   // shifting on idle cycles and wipes partial windows after a stall or at row start.
   assign sipo_en     = acc;
   assign sipo_ser_in = in_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         win_valid  <= 1'b0;
         win_row    <= '0;
         win_col    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
         row        <= '0;
         col        <= '0;
         run        <= '0;
      end else if (abort) begin
         // Same as reset, but the underrun flag survives so software can still see it.
         state      <= IDLE;
         in_ready   <= 1'b0;
         win_valid  <= 1'b0;
         win_row    <= '0;
         win_col    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         row        <= '0;
         col        <= '0;
         run        <= '0;
      end else begin
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= FLUSH;
                  busy     <= 1'b1;
                  underrun <= 1'b0;
                  row      <= '0;
               end
            end
            FLUSH: begin
               // in_ready is low here, so sipo_en is low and the SIPO is cleared.
               state    <= STREAM;
               in_ready <= 1'b1;
               col      <= '0;
               run      <= '0;
            end
            STREAM: begin
               if (acc) begin
                  // This word completes a window if N-1 good words precede it.
                  if (run >= RUN_PRE) begin
                     win_valid <= 1'b1;
                     win_col   <= col - COL_BACK;
                     win_row   <= row;
                  end
                  if (run != RUN_FULL)
                     run <= run + 1'b1;
                  col <= col + 1'b1;
                  if (col == COL_LAST) begin
                     in_ready <= 1'b0;
                     if (row == ROW_LAST) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                     end else begin
                        row   <= row + 1'b1;
                        state <= FLUSH;
                     end
                  end
               end else if (!in_valid && run != '0) begin
                  // Mid-row stall: the SIPO was just cleared, so refill from scratch
                  // while col keeps tracking the true image position.
                  run      <= '0;
                  underrun <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: directed bench for conv_window_ctrl with a frame-level reference model.
// The model tracks the frame as a count of accepted words (row = k / IMG_W, col = k % IMG_W)
// and a run length of words since the SIPO was last cleared; a SIPO model rebuilds par_out.
module tb_conv_window_ctrl;
   localparam int N     = 3;
   localparam int PB    = 8;
   localparam int IMG_W = 8;
   localparam int IMG_H = 4;
   localparam int WW    = 2 * PB;

   localparam int PH_IDLE   = 0;
   localparam int PH_GAP    = 1;
   localparam int PH_STREAM = 2;
   localparam int PH_END    = 3;

   logic          clk = 1'b0;
   logic          rst, start, abort, in_valid;
   logic [WW-1:0] in_data;
   logic          in_ready, sipo_en, win_valid, busy, frame_done, underrun;
   logic [WW-1:0] sipo_ser_in;
   logic [1:0]    win_row;
   logic [2:0]    win_col;

   always #5 clk = ~clk;

   conv_window_ctrl #(.N(N), .PB(PB), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .sipo_en(sipo_en), .sipo_ser_in(sipo_ser_in),
      .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
      .busy(busy), .frame_done(frame_done), .underrun(underrun)
   );

   // SIPO: newest word enters at the top; a low enable clears it.
   logic [WW*N-1:0] par = '0;
   always @(posedge clk)
      par <= sipo_en ? {sipo_ser_in, par[WW*N-1:WW]} : '0;

   // Reference model.
   int m_phase = PH_IDLE, m_k = 0, m_streak = 0, e_wrow = 0, e_wcol = 0;
   bit m_under = 1'b0, e_wv = 1'b0, model_live = 1'b0;

   always @(posedge clk) begin
      model_live <= 1'b1;
      e_wv       <= 1'b0;
      if (rst) begin
         m_phase <= PH_IDLE; m_k <= 0; m_streak <= 0; m_under <= 1'b0;
      end else if (abort) begin
         m_phase <= PH_IDLE; m_k <= 0; m_streak <= 0;
      end else begin
         case (m_phase)
            PH_IDLE: if (start) begin
               m_phase <= PH_GAP; m_under <= 1'b0; m_k <= 0;
            end
            PH_GAP: begin
               m_phase <= PH_STREAM; m_streak <= 0;
            end
            PH_STREAM: begin
               if (in_valid) begin
                  e_wv     <= (m_streak + 1 >= N);
                  e_wrow   <= m_k / IMG_W;
                  e_wcol   <= m_k % IMG_W - (N - 1);
                  m_streak <= (m_streak + 1 > N) ? N : m_streak + 1;
                  m_k      <= m_k + 1;
                  if ((m_k + 1) % IMG_W == 0)
                     m_phase <= (m_k + 1 == IMG_W * IMG_H) ? PH_END : PH_GAP;
               end else if (m_streak > 0) begin
                  m_streak <= 0; m_under <= 1'b1;
               end
            end
            default: m_phase <= PH_IDLE;
         endcase
      end
   end

   int checks = 0, failures = 0;
   int wv_tot[IMG_H] = '{default: 0};
   int done_tot = 0;
   bit grab_first = 1'b0;
   logic [WW*N-1:0] got_par = '0;
   logic [2:0]      got_col = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_cycle();
      bit e_ready;
      e_ready = (m_phase == PH_STREAM);
      chk("in_ready", in_ready, e_ready);
      chk("sipo_en", sipo_en, e_ready && in_valid);
      chk("sipo_ser_in", sipo_ser_in, in_data);
      chk("win_valid", win_valid, e_wv);
      if (e_wv) begin
         chk("win_row", win_row, e_wrow);
         chk("win_col", win_col, e_wcol);
      end
      chk("busy", busy, m_phase != PH_IDLE);
      chk("frame_done", frame_done, m_phase == PH_END);
      chk("underrun", underrun, m_under);
      if (win_valid === 1'b1) begin
         wv_tot[win_row]++;
         if (grab_first) begin
            got_par    = par;
            got_col    = win_col;
            grab_first = 1'b0;
         end
      end
      if (frame_done === 1'b1) done_tot++;
   endtask

   // One clock: compare on the falling edge, then move inputs just after the rising edge.
   task automatic step();
      @(negedge clk);
      if (model_live) compare_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input bit do_start, input int drop_k, input int wait_k,
                            input int abort_k, input int istart_k);
      int cyc = 0, waits = 0;
      bit dropped = 1'b0, aborted = 1'b0, istarted = 1'b0;
      if (do_start) begin
         start = 1'b1; step(); start = 1'b0;
      end
      while (m_phase != PH_IDLE && cyc < 400) begin
         in_valid = 1'b1; start = 1'b0; abort = 1'b0;
         if (m_phase == PH_STREAM) begin
            if (m_k == drop_k && !dropped) begin in_valid = 1'b0; dropped = 1'b1; end
            if (m_k == wait_k && waits < 3) begin in_valid = 1'b0; waits++; end
            if (m_k == abort_k && !aborted) begin abort = 1'b1; aborted = 1'b1; end
            if (m_k == istart_k && !istarted) begin start = 1'b1; istarted = 1'b1; end
         end
         in_data = {2{8'(m_k % IMG_W + 1)}};
         step();
         cyc++;
      end
      chk("frame_ends_in_budget", cyc < 400, 1);
      in_valid = 1'b0; start = 1'b0; abort = 1'b0;
   endtask

   int snap[IMG_H];
   int dsnap;

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
      @(posedge clk); #1;
      step(); step();
      rst = 1'b0;
      chk("reset_outputs", {in_ready, sipo_en, win_valid, busy, frame_done, underrun, win_row, win_col}, 0);
      step();

      // Full frame with in_valid held high, plus first-window alignment.
      snap = wv_tot; dsnap = done_tot; grab_first = 1'b1;
      run_frame(1'b1, -1, -1, -1, -1);
      for (int r = 0; r < IMG_H; r++) chk($sformatf("full_row%0d_windows", r), wv_tot[r] - snap[r], 6);
      chk("full_done_pulses", done_tot - dsnap, 1);
      chk("first_window_par", got_par, 48'h030302020101);
      chk("first_window_col", got_col, 0);

      // One-cycle stall after column 4 of row 1.
      snap = wv_tot;
      run_frame(1'b1, IMG_W + 5, -1, -1, -1);
      chk("underrun_row1_windows", wv_tot[1] - snap[1], 4);
      chk("underrun_row0_windows", wv_tot[0] - snap[0], 6);
      chk("underrun_sticky", underrun, 1);

      // Three idle cycles at the start of row 2 are a wait, not an underrun.
      snap = wv_tot;
      run_frame(1'b1, -1, 2 * IMG_W, -1, -1);
      chk("rowstart_wait_no_underrun", underrun, 0);
      chk("rowstart_wait_row2_windows", wv_tot[2] - snap[2], 6);

      // Stall in row 0, ignored start mid-row, abort in row 2.
      snap = wv_tot; dsnap = done_tot;
      run_frame(1'b1, 5, -1, 2 * IMG_W + 3, 3);
      chk("abort_busy", busy, 0);
      chk("abort_no_done", done_tot - dsnap, 0);
      chk("abort_keeps_underrun", underrun, 1);
      chk("abort_row0_windows", wv_tot[0] - snap[0], 4);
      chk("abort_row2_windows", wv_tot[2] - snap[2], 1);

      // start together with abort stays idle; start alone begins a clean frame.
      start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
      chk("start_abort_same_cycle_busy", busy, 0);
      start = 1'b1; step(); start = 1'b0;
      chk("restart_clears_underrun", underrun, 0);
      chk("restart_busy", busy, 1);
      snap = wv_tot;
      run_frame(1'b0, -1, -1, -1, -1);
      chk("restart_total_windows",
          (wv_tot[0] - snap[0]) + (wv_tot[1] - snap[1]) + (wv_tot[2] - snap[2]) + (wv_tot[3] - snap[3]), 24);

      // Reset held two cycles in the middle of a row.
      start = 1'b1; step(); start = 1'b0;
      in_valid = 1'b1;
      repeat (10) begin in_data = {2{8'(m_k % IMG_W + 1)}}; step(); end
      rst = 1'b1; step(); step(); rst = 1'b0;
      chk("midstream_reset_outputs",
          {in_ready, sipo_en, win_valid, busy, frame_done, underrun, win_row, win_col}, 0);
      step();
      chk("after_reset_gated_sipo_en", {in_ready, sipo_en, busy}, 0);
      in_valid = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
